// File: rtl/seg_display_scan_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   DIGIT_W    : bits per displayed digit (hex nibble or BCD digit)
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DASH   : only segment g lit, used to flag overflow
//   conv_state_t : double-dabble sequencer states
//   seg_glyph() : nibble -> active-low {g,f,e,d,c,b,a} pattern
package seg_display_scan_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_t;

  // Standard glyphs; 0xA-0xF render as A,b,C,d,E,F.
  function automatic logic [6:0] seg_glyph(input logic [DIGIT_W-1:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_display_scan_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
//   clk, rst : clock, asynchronous active-high reset (aborts a conversion)
//   start    : begin a conversion of bin (ignored while busy)
//   bin      : binary input, captured on an accepted start
//   busy     : conversion in progress
//   done     : high in the last conversion cycle; bcd/ovf are final then
//   bcd      : NUM_DIGITS packed BCD digits, digit 0 in the low nibble
//   ovf      : a 1 was shifted out of the top BCD digit (value too large)
module bin2bcd_seq
  import seg_display_scan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         bin,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_DIGITS*DIGIT_W-1:0] bcd,
  output logic                          ovf
);

  localparam int unsigned      BCD_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned      CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);

  conv_state_t          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]     r_bcd;
  logic                 r_ovf;

  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_bcd_next;
  logic                 w_ovf_next;
  logic                 w_last;

  // Add-3 correction on every digit >= 5 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        w_adj[i*DIGIT_W +: DIGIT_W] = r_bcd[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
  end

  assign w_bcd_next = {w_adj[BCD_W-2:0], r_bin[DATA_WIDTH-1]};
  assign w_ovf_next = r_ovf | w_adj[BCD_W-1];
  assign w_last     = (r_state == ST_CONV) && (r_cnt == LAST);

  // Outputs expose the post-iteration value so the consumer can capture the
  // final result on the same edge that ends the conversion.
  assign busy = (r_state == ST_CONV);
  assign done = w_last;
  assign bcd  = w_bcd_next;
  assign ovf  = w_ovf_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd <= w_bcd_next;
          r_bin <= r_bin << 1;
          r_ovf <= w_ovf_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed common-anode seven-segment driver.
//   clk, rst : clock, asynchronous active-high reset
//   value    : binary number, sampled on an accepted load
//   load     : one-cycle strobe, ignored while busy
//   mode_dec : sampled with load; 1 = decimal via double-dabble, 0 = hex
//   blank_lz : live; blank leading zero digits (digit 0 always shown)
//   busy     : decimal conversion in progress
//   overflow : last loaded value does not fit in NUM_DIGITS digits
//   an       : active-low digit enables, one-hot-low
//   seg      : active-low segments {g,f,e,d,c,b,a}
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  load,
  input  logic                  mode_dec,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int unsigned BCD_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned EXT_W = (DATA_WIDTH > BCD_W) ? DATA_WIDTH : BCD_W;
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [BCD_W-1:0]      r_dig;
  logic                  r_overflow;
  logic [DIV_W-1:0]      r_div;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  logic                  w_busy;
  logic                  w_done;
  logic [BCD_W-1:0]      w_bcd;
  logic                  w_bcd_ovf;
  logic                  w_accept;
  logic                  w_start;
  logic [EXT_W-1:0]      w_value_ext;
  logic [BCD_W-1:0]      w_hex_dig;
  logic                  w_hex_ovf;
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic                  w_above_zero;
  logic [DIGIT_W-1:0]    w_cur_nib;
  logic                  w_cur_blank;
  logic [6:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  // ---------------------------------------------------------------- load path
  assign w_accept = load & ~w_busy;
  assign w_start  = w_accept & mode_dec;

  assign w_value_ext = EXT_W'(value);
  assign w_hex_dig   = w_value_ext[BCD_W-1:0];
  assign w_hex_ovf   = |(w_value_ext >> BCD_W);

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (value),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd),
    .ovf   (w_bcd_ovf)
  );

  assign busy     = w_busy;
  assign overflow = r_overflow;

  // done implies busy, so a hex accept and a conversion result never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig      <= '0;
      r_overflow <= 1'b0;
    end else if (w_done) begin
      r_dig      <= w_bcd;
      r_overflow <= w_bcd_ovf;
    end else if (w_accept && !mode_dec) begin
      r_dig      <= w_hex_dig;
      r_overflow <= w_hex_ovf;
    end
  end

  // ---------------------------------------------------------------- scanning
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // w_lead_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    w_lead_zero  = '0;
    w_above_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_above_zero = w_above_zero &
                     (r_dig[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] == '0);
      w_lead_zero[NUM_DIGITS-1-k] = w_above_zero;
    end
  end

  assign w_cur_nib   = r_dig[r_idx*DIGIT_W +: DIGIT_W];
  assign w_cur_blank = blank_lz && (r_idx != '0) && w_lead_zero[r_idx];

  always_comb begin
    if (r_overflow) begin
      w_seg_next = SEG_DASH;
    end else if (w_cur_blank) begin
      w_seg_next = SEG_BLANK;
    end else begin
      w_seg_next = seg_glyph(w_cur_nib);
    end
  end

  assign w_an_next = ~(NUM_DIGITS'(1) << r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_seg_display_scan.sv
module tb_seg_display_scan;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef struct {
    logic [15:0] digs;
    bit          ovf;
    int          busy_cycles;
  } exp_t;

  exp_t sb_q[$];

  logic        clk;
  logic        rst;
  logic        mode_dec;
  logic        blank_lz;
  logic [15:0] value16;
  logic        load16;
  logic        busy16, ovf16;
  logic [3:0]  an16;
  logic [6:0]  seg16;
  logic [19:0] value20;
  logic        load20;
  logic        busy20, ovf20;
  logic [3:0]  an20;
  logic [6:0]  seg20;

  bit          sel;
  logic        mon_busy, mon_ovf;
  logic [3:0]  mon_an;
  logic [6:0]  mon_seg;

  int n_tests = 0;
  int n_fail  = 0;

  seg_display_scan #(
    .NUM_DIGITS  (4),
    .DATA_WIDTH  (16),
    .REFRESH_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value16),
    .load     (load16),
    .mode_dec (mode_dec),
    .blank_lz (blank_lz),
    .busy     (busy16),
    .overflow (ovf16),
    .an       (an16),
    .seg      (seg16)
  );

  seg_display_scan #(
    .NUM_DIGITS  (4),
    .DATA_WIDTH  (20),
    .REFRESH_DIV (4)
  ) dut20 (
    .clk      (clk),
    .rst      (rst),
    .value    (value20),
    .load     (load20),
    .mode_dec (mode_dec),
    .blank_lz (blank_lz),
    .busy     (busy20),
    .overflow (ovf20),
    .an       (an20),
    .seg      (seg20)
  );

  assign mon_busy = sel ? busy20 : busy16;
  assign mon_ovf  = sel ? ovf20  : ovf16;
  assign mon_an   = sel ? an20   : an16;
  assign mon_seg  = sel ? seg20  : seg16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input bit ovf,
                                         input bit blk, input int k);
    bit lz = 1'b1;
    for (int j = 3; j >= k; j--) begin
      if (d[j*4 +: 4] != 4'h0) lz = 1'b0;
    end
    if (ovf) return DASH;
    if (blk && k > 0 && lz) return BLANK;
    return GLYPH[d[k*4 +: 4]];
  endfunction

  // Called at a negedge: compute expectation, drive a one-cycle load.
  task automatic drive_load(input bit s, input int unsigned v, input bit dec);
    exp_t e;
    int unsigned p = 1;
    e.digs = '0;
    if (dec) begin
      for (int i = 0; i < 4; i++) begin
        e.digs[i*4 +: 4] = 4'((v / p) % 10);
        p = p * 10;
      end
      e.ovf         = (v >= 10000);
      e.busy_cycles = s ? 20 : 16;
    end else begin
      e.digs        = v[15:0];
      e.ovf         = ((v >> 16) != 0);
      e.busy_cycles = 0;
    end
    sb_q.push_back(e);
    sel      = s;
    mode_dec = dec;
    if (s) begin
      value20 = v[19:0];
      load20  = 1'b1;
    end else begin
      value16 = v[15:0];
      load16  = 1'b1;
    end
    @(negedge clk);
    load16 = 1'b0;
    load20 = 1'b0;
  endtask

  // Pops the scoreboard, measures busy length; stray_at >= 0 injects a
  // decimal load into the busy window, which must be ignored.
  task automatic wait_done(input int stray_at, output exp_t e);
    int n = 0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
      e.digs = '0; e.ovf = 1'b0; e.busy_cycles = 0;
      return;
    end
    e = sb_q.pop_front();
    while (mon_busy && n < 64) begin
      if (n == stray_at) begin
        mode_dec = 1'b1;
        value16  = 16'd1111;
        load16   = 1'b1;
      end
      @(negedge clk);
      load16 = 1'b0;
      n++;
    end
    check("busy_len", n, e.busy_cycles);
    check("overflow", mon_ovf, e.ovf);
  endtask

  task automatic check_scan(input logic [15:0] digs, input bit ovf);
    logic [3:0] prev;
    logic [3:0] ea;
    int         w = 0;
    bit         found = 1'b0;
    prev = mon_an;
    while (!found && w < 64) begin
      @(negedge clk);
      w++;
      if (mon_an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = mon_an;
    end
    check("scan_sync", found, 1);
    for (int t = 0; t < 16; t++) begin
      ea = ~(4'b0001 << (t / 4));
      check($sformatf("scan_an_t%0d", t), mon_an, ea);
      check($sformatf("scan_seg_d%0d", t / 4), mon_seg,
            exp_seg(digs, ovf, blank_lz, t / 4));
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; mode_dec = 1'b0; blank_lz = 1'b0; sel = 1'b0;
    value16 = '0; load16 = 1'b0; value20 = '0; load20 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an",   an16,   4'hF);
    check("rst_seg",  seg16,  BLANK);
    check("rst_busy", busy16, 0);
    check("rst_ovf",  ovf16,  0);
    rst = 1'b0;
    @(negedge clk);
    check("first_an",  an16,  4'b1110);
    check("first_seg", seg16, GLYPH[0]);

    // Hex split
    drive_load(0, 32'h1A3F, 0);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    // Decimal conversions
    drive_load(0, 9876, 1);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    drive_load(0, 10000, 1);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    blank_lz = 1'b1;
    drive_load(0, 42, 1);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    drive_load(0, 0, 1);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);
    blank_lz = 1'b0;

    // Load accepted in the cycle busy falls
    drive_load(0, 321, 1);
    wait_done(-1, e);
    drive_load(0, 32'hBEEF, 0);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    // Load during busy is ignored
    drive_load(0, 9876, 1);
    wait_done(4, e);
    check_scan(e.digs, e.ovf);

    // Reset mid-conversion, with a stray hex load at cycle 5
    mode_dec = 1'b1; value16 = 16'd1234; load16 = 1'b1;
    @(negedge clk);
    load16 = 1'b0;
    repeat (4) @(negedge clk);
    mode_dec = 1'b0; value16 = 16'h00FF; load16 = 1'b1;
    @(negedge clk);
    load16 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_pre_rst", busy16, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy16, 0);
    check("midrst_ovf",  ovf16,  0);
    check("midrst_an",   an16,   4'hF);
    check("midrst_seg",  seg16,  BLANK);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_first_an", an16, 4'b1110);
    check_scan(16'h0000, 1'b0);

    // 20-bit instance
    drive_load(1, 32'h10000, 0);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    drive_load(1, 32'h0ABCD, 0);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    drive_load(1, 9999, 1);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    drive_load(1, 99999, 1);
    wait_done(-1, e);
    check_scan(e.digs, e.ovf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
